// File: rtl/bcd_cascade_counter_pkg.sv
// Shared constants and helpers for the cascaded BCD counter and its digit cells.
package bcd_cascade_counter_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BCD_MAX = 9;

    // Minimum binary width able to hold tens_mod*units_mod-1.
    function automatic int unsigned bin_width(input int unsigned tens_mod,
                                              input int unsigned units_mod);
        return $clog2(tens_mod * units_mod);
    endfunction

    // An out-of-range loaded digit collapses to zero.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                       input int unsigned modulus);
        return (32'(d) >= modulus) ? '0 : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit cell: clear/load/increment with a combinational wrap strobe for cascading.
module bcd_digit
    import bcd_cascade_counter_pkg::*;
#(
    parameter int unsigned MOD = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_d,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               wrap
);

    localparam logic [DIGIT_W-1:0] QMAX = DIGIT_W'(MOD - 1);

    if (MOD < 2 || MOD > BCD_MAX + 1) begin : g_mod_check
        $error("bcd_digit: MOD out of range 2..10");
    end

    logic [DIGIT_W-1:0] q_d;

    assign wrap = inc & (q == QMAX);

    always_comb begin
        q_d = q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = clamp_digit(load_d, MOD);
        end else if (inc) begin
            q_d = wrap ? '0 : q + DIGIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/bcd_cascade_counter.sv
// Two-digit cascaded BCD counter (default 00..59) with binary mirror and wrap carry pulse.
module bcd_cascade_counter
    import bcd_cascade_counter_pkg::*;
#(
    parameter int unsigned UNITS_MOD = 10,
    parameter int unsigned TENS_MOD  = 6,
    parameter int unsigned BIN_W     = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               tick_in,
    input  logic               clr,
    input  logic               load,
    input  logic [7:0]         load_val,
    output logic [DIGIT_W-1:0] units,
    output logic [DIGIT_W-1:0] tens,
    output logic [BIN_W-1:0]   bin_count,
    output logic               at_max,
    output logic               carry_out
);

    localparam int unsigned        MIN_BIN_W   = bin_width(TENS_MOD, UNITS_MOD);
    localparam logic [BIN_W-1:0]   UNITS_MOD_W = BIN_W'(UNITS_MOD);
    localparam logic [DIGIT_W-1:0] UNITS_MAX   = DIGIT_W'(UNITS_MOD - 1);
    localparam logic [DIGIT_W-1:0] TENS_MAX    = DIGIT_W'(TENS_MOD - 1);

    if (BIN_W < MIN_BIN_W) begin : g_bin_w_check
        $error("bcd_cascade_counter: BIN_W too narrow for TENS_MOD*UNITS_MOD-1");
    end

    logic             step;
    logic             units_wrap;
    logic             tens_wrap;
    logic [BIN_W-1:0] load_bin;
    logic [BIN_W-1:0] bin_d;

    // Clear and load win over the tick, so the cascade never fires on those edges.
    assign step = tick_in & en & ~clr & ~load;

    bcd_digit #(
        .MOD (UNITS_MOD)
    ) u_units (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .load   (load),
        .load_d (load_val[3:0]),
        .inc    (step),
        .q      (units),
        .wrap   (units_wrap)
    );

    bcd_digit #(
        .MOD (TENS_MOD)
    ) u_tens (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .load   (load),
        .load_d (load_val[7:4]),
        .inc    (units_wrap),
        .q      (tens),
        .wrap   (tens_wrap)
    );

    assign load_bin = BIN_W'(clamp_digit(load_val[7:4], TENS_MOD)) * UNITS_MOD_W
                    + BIN_W'(clamp_digit(load_val[3:0], UNITS_MOD));

    always_comb begin
        bin_d = bin_count;
        if (clr) begin
            bin_d = '0;
        end else if (load) begin
            bin_d = load_bin;
        end else if (step) begin
            bin_d = tens_wrap ? '0 : bin_count + BIN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_count <= '0;
            carry_out <= 1'b0;
        end else begin
            bin_count <= bin_d;
            carry_out <= tens_wrap;
        end
    end

    assign at_max = (tens == TENS_MAX) && (units == UNITS_MAX);

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Self-checking bench: vector table, directed corner sequences and a randomized model run.
module tb_bcd_cascade_counter;

    localparam int unsigned UM   = 10;
    localparam int unsigned TM   = 6;
    localparam int unsigned BW   = 7;
    localparam int          VMAX = UM * TM - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          tick_in;
    logic          clr;
    logic          load;
    logic [7:0]    load_val;
    logic [3:0]    units;
    logic [3:0]    tens;
    logic [BW-1:0] bin_count;
    logic          at_max;
    logic          carry_out;

    bcd_cascade_counter #(
        .UNITS_MOD (UM),
        .TENS_MOD  (TM),
        .BIN_W     (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .tick_in   (tick_in),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
        .units     (units),
        .tens      (tens),
        .bin_count (bin_count),
        .at_max    (at_max),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: the count as one plain integer 0..VMAX plus the pending carry pulse.
    int mv = 0;
    int mc = 0;

    typedef struct {
        logic       clr;
        logic       load;
        logic [7:0] lv;
        logic       en;
        logic       tick;
        int         exp_tens;
        int         exp_units;
        int         exp_carry;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_model(input string name);
        chk({name, ".units"}, int'(units), mv % UM);
        chk({name, ".tens"}, int'(tens), mv / UM);
        chk({name, ".bin"}, int'(bin_count), mv);
        chk({name, ".at_max"}, int'(at_max), (mv == VMAX) ? 1 : 0);
        chk({name, ".carry"}, int'(carry_out), mc);
    endtask

    function automatic int clampd(input int d, input int m);
        return (d >= m) ? 0 : d;
    endfunction

    task automatic drive(input logic c, input logic l, input logic [7:0] lv,
                         input logic e, input logic t);
        clr      = c;
        load     = l;
        load_val = lv;
        en       = e;
        tick_in  = t;
    endtask

    // Advance the model using the inputs present before the edge, then clock.
    task automatic cycle();
        if (clr) begin
            mv = 0;
            mc = 0;
        end else if (load) begin
            mv = clampd(int'(load_val[7:4]), TM) * UM + clampd(int'(load_val[3:0]), UM);
            mc = 0;
        end else if (en && tick_in) begin
            if (mv == VMAX) begin
                mv = 0;
                mc = 1;
            end else begin
                mv = mv + 1;
                mc = 0;
            end
        end else begin
            mc = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            cycle();
            chk("tick_carry", int'(carry_out), mc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        mv = 0;
        mc = 0;
        chk_model("in_reset");
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        chk_model("post_release");
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 8'h57, 1'b0, 1'b0, 5, 7, 0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5, 8, 0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5, 9, 0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0, 0, 1};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1, 0};
        vecs[5]  = '{1'b0, 1'b1, 8'h7C, 1'b1, 1'b0, 0, 0, 0};
        vecs[6]  = '{1'b0, 1'b1, 8'h59, 1'b1, 1'b1, 5, 9, 0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5, 9, 0};
        vecs[8]  = '{1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 0, 0, 0};
        vecs[9]  = '{1'b0, 1'b1, 8'h3A, 1'b0, 1'b0, 3, 0, 0};
        vecs[10] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 0, 5, 0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 5, 0};

        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_reset();

        // Vector table, applied in sequence from 00.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].tick);
            cycle();
            chk($sformatf("vec%0d.units", i), int'(units), vecs[i].exp_units);
            chk($sformatf("vec%0d.tens", i), int'(tens), vecs[i].exp_tens);
            chk($sformatf("vec%0d.bin", i), int'(bin_count),
                vecs[i].exp_tens * 10 + vecs[i].exp_units);
            chk($sformatf("vec%0d.carry", i), int'(carry_out), vecs[i].exp_carry);
        end

        // Units rollover from 00.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        ticks(10);
        chk("rollover.tens", int'(tens), 1);
        chk("rollover.units", int'(units), 0);
        chk("rollover.bin", int'(bin_count), 10);

        // Full wrap from 00.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        ticks(59);
        chk("wrap59.at_max", int'(at_max), 1);
        chk("wrap59.bin", int'(bin_count), 59);
        ticks(1);
        chk("wrap60.bin", int'(bin_count), 0);
        chk("wrap60.carry", int'(carry_out), 1);
        ticks(1);
        chk("wrap61.units", int'(units), 1);
        chk("wrap61.carry", int'(carry_out), 0);

        // Asynchronous reset between edges at 34.
        drive(1'b0, 1'b1, 8'h34, 1'b0, 1'b0);
        cycle();
        chk_model("at34");
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        mv = 0;
        mc = 0;
        chk_model("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        ticks(5);
        chk("recount.units", int'(units), 5);
        chk("recount.tens", int'(tens), 0);
        chk("recount.bin", int'(bin_count), 5);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 40) == 0, $urandom_range(0, 15) == 0,
                  8'($urandom_range(0, 255)), $urandom_range(0, 9) < 8,
                  $urandom_range(0, 9) < 7);
            cycle();
            chk_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_cascade_counter.md
Name: bcd_cascade_counter

Overview:
- Two-digit cascaded BCD counter, downstream of the mod-n counter stage.
- Consumes that stage's one-cycle terminal-count pulse as `tick_in`.
- Default configuration counts 00..59 (seconds/minutes style).
- Emits a one-cycle carry on full wrap, so further stages can chain off it.

Parameters:
- UNITS_MOD, 10: modulus of the units digit; legal 2..10.
- TENS_MOD, 6: modulus of the tens digit; legal 2..10.
- BIN_W, 7: width of the binary-equivalent output; must hold TENS_MOD*UNITS_MOD-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; gates `tick_in`.
- tick_in  input  1  one-cycle increment request from the upstream mod-n stage.
- clr  input  1  synchronous clear to 00.
- load  input  1  synchronous load strobe.
- load_val  input  8  [7:4] tens digit, [3:0] units digit, BCD.
- units  output  4  units digit, registered.
- tens  output  4  tens digit, registered.
- bin_count  output  BIN_W  tens*UNITS_MOD+units, registered.
- at_max  output  1  high while tens==TENS_MOD-1 and units==UNITS_MOD-1.
- carry_out  output  1  registered one-cycle pulse on full wrap.

Behaviour:
- Reset: rst low asynchronously forces units=0, tens=0, bin_count=0, carry_out=0. at_max then reads 0.
  - Release is synchronous to clk.
  - rst asserted mid-count discards all state.
- Priority on each rising edge: clr > load > count.
- clr=1: units=0, tens=0, bin_count=0, carry_out=0. Any tick on the same edge is ignored.
- load=1 (clr=0):
  - units and tens take load_val[3:0] and load_val[7:4].
  - A digit >= its modulus loads as 0 (per digit, independently).
  - bin_count is updated consistently on the same edge.
  - carry_out=0; a coincident tick is ignored.
- Count step (tick_in=1 and en=1, no clr/load):
  - units<UNITS_MOD-1: units+1, tens unchanged.
  - units==UNITS_MOD-1 and tens<TENS_MOD-1: units=0, tens+1.
  - Both at max: units=0, tens=0, and carry_out=1 on the following cycle only.
  - bin_count tracks every step: +1, or 0 on wrap.
- tick_in=1 with en=0, or tick_in=0: hold all state; carry_out=0.
- Latency: digits and bin_count update on the edge that samples the tick.
- carry_out:
  - Asserts for exactly one cycle, registered on the wrapping edge.
  - Back-to-back ticks at max give one pulse per wrap.
  - A tick held high continuously advances one count per cycle. No edge detection on tick_in; upstream guarantees pulse width.
- at_max is combinational from the digit registers only; no input path.
- Digit registers never hold a value >= their modulus.

Decomposition:
- Shared package: digit width constant (4), BCD max constant (9), function computing BIN_W from the two moduli.
- Sub-module `bcd_digit`, instantiated twice:
  - Parameter MOD; inputs clk, rst, clr, load, load_d, inc.
  - Outputs q and wrap, where wrap = inc & (q==MOD-1), combinational.
  - Cascade: tens.inc = units.wrap; carry_out register fed by tens.wrap.
- bin_count computed in the top level as a registered multiply-add; a constant multiply only.

Test Plan:
- Reset and release: hold rst=0 with ticks active, release -> units=0, tens=0, bin_count=0, carry_out=0, at_max=0 until the first tick.
- Units rollover: 10 ticks from 00 -> tens=1, units=0, bin_count=10, carry_out stays 0.
- Full wrap:
  - 59 ticks from 00 -> at_max=1, bin_count=59.
  - 60th tick -> 00, carry_out=1 for exactly one cycle.
  - A tick on the next cycle -> 01 and carry_out=0.
- Load, clamp and enable: load_val=8'h57 -> 57, bin_count=57. load_val=8'h7C -> 00 (both digits illegal). Ticks with en=0 -> value held.
- Simultaneous events: clr and load and tick on one edge -> 00. load=8'h59 with tick -> 59, not 00, and no carry.
- Async reset mid-operation: rst low between edges at value 34 -> outputs 0 immediately, before the next clk edge. Recount of 5 ticks after release -> 05.
